// File: rtl/updown_pkg.sv
// Shared types and constant helpers for the up/down counter controller.
//   state_t    : controller state encoding (3 bits)
//   ms_to_cyc  : milliseconds -> clock cycles at a given clock frequency
//   tmr_width  : timer register width able to hold the largest reload value
package updown_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INC_WAIT = 3'd1,
    S_INC_RPT  = 3'd2,
    S_DEC_WAIT = 3'd3,
    S_DEC_RPT  = 3'd4,
    S_BOTH     = 3'd5
  } state_t;

  function automatic int unsigned ms_to_cyc(input int unsigned ms, input int unsigned clk_hz);
    return ms * (clk_hz / 32'd1000);
  endfunction

  function automatic int unsigned tmr_width(input int unsigned dly, input int unsigned per,
                                            input int unsigned clr);
    int unsigned m;
    m = (dly > per) ? dly : per;
    m = (clr > m) ? clr : m;
    return $clog2(m + 32'd1);
  endfunction

endpackage

// File: rtl/updown_ctrl_cyc_timer.sv
// Down-counting cycle timer shared by every controller state.
//   clk, rst     : clock, async active-high reset (value -> 0)
//   i_load       : load i_load_val this cycle (wins over counting)
//   i_load_val   : reload value, must be >= 1 for a meaningful expiry
//   i_en         : count down while nonzero
//   o_value      : current timer value
//   o_expire     : high in the cycle whose clock edge ends the interval
module cyc_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_en,
  output logic [TW-1:0] o_value,
  output logic          o_expire
);

  logic [TW-1:0] r_value;

  // Timer register: load has priority, otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= {TW{1'b0}};
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_en && (r_value != {TW{1'b0}})) begin
      r_value <= r_value - TW'(1);
    end else begin
      r_value <= r_value;
    end
  end

  // A value of one means the upcoming edge completes the loaded interval.
  assign o_expire = i_en && (r_value == TW'(1));
  assign o_value  = r_value;

endmodule

// File: rtl/updown_ctrl.sv
// Up/down counter controller behind the LED display.
//   clk, rst              : clock, async active-high reset
//   inc_press, inc_held   : up button press pulse / debounced level
//   dec_press, dec_held   : down button press pulse / debounced level
//   cnt, led              : count and its active-low LED image (led == ~cnt)
//   step                  : one-cycle pulse on any count change
//   rpt_active            : high while auto-repeating
//   cleared               : one-cycle pulse when the both-held clear fires
module updown_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 27_000_000,
  parameter int unsigned WIDTH            = 6,
  parameter int unsigned REPEAT_DELAY_MS  = 500,
  parameter int unsigned REPEAT_PERIOD_MS = 100,
  parameter int unsigned CLEAR_MS         = 1000,
  parameter bit          SATURATE         = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_press,
  input  logic             inc_held,
  input  logic             dec_press,
  input  logic             dec_held,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             rpt_active,
  output logic             cleared
);

  localparam int unsigned DLY = ms_to_cyc(REPEAT_DELAY_MS, CLK_HZ);
  localparam int unsigned PER = ms_to_cyc(REPEAT_PERIOD_MS, CLK_HZ);
  localparam int unsigned CLR = ms_to_cyc(CLEAR_MS, CLK_HZ);
  localparam int unsigned TW  = tmr_width(DLY, PER, CLR);

  localparam logic [TW-1:0]    DLY_V   = TW'(DLY);
  localparam logic [TW-1:0]    PER_V   = TW'(PER);
  localparam logic [TW-1:0]    CLR_V   = TW'(CLR);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_led;
  logic             r_step;
  logic             r_rpt;
  logic             r_clr;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_step_next;
  logic             w_clr_next;
  logic             w_up_req;
  logic             w_dn_req;
  logic             w_clr_req;
  logic             w_load;
  logic [TW-1:0]    w_load_val;
  logic             w_tmr_en;
  logic [TW-1:0]    w_tmr_val;
  logic             w_tmr_zero;
  logic             w_expire;
  logic             w_can_inc;
  logic             w_can_dec;

  cyc_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_tmr_en),
    .o_value    (w_tmr_val),
    .o_expire   (w_expire)
  );

  assign w_tmr_en   = (r_state != S_IDLE);
  // In BOTH the timer only reaches zero once the clear has fired.
  assign w_tmr_zero = (w_tmr_val == {TW{1'b0}});
  assign w_can_inc  = (SATURATE == 1'b0) || (r_cnt != CNT_MAX);
  assign w_can_dec  = (SATURATE == 1'b0) || (r_cnt != CNT_MIN);

  // Next-state, timer reload and count-update decisions.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = DLY_V;
    w_up_req     = 1'b0;
    w_dn_req     = 1'b0;
    w_clr_req    = 1'b0;
    w_cnt_next   = r_cnt;
    w_step_next  = 1'b0;
    w_clr_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((inc_press && dec_press) || (inc_press && dec_held) || (dec_press && inc_held)) begin
          w_next_state = S_BOTH;
          w_load       = 1'b1;
          w_load_val   = CLR_V;
        end else if (inc_press) begin
          w_next_state = S_INC_WAIT;
          w_load       = 1'b1;
          w_load_val   = DLY_V;
          w_up_req     = 1'b1;
        end else if (dec_press) begin
          w_next_state = S_DEC_WAIT;
          w_load       = 1'b1;
          w_load_val   = DLY_V;
          w_dn_req     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_INC_WAIT, S_INC_RPT: begin
        if (dec_held) begin
          w_next_state = S_BOTH;
          w_load       = 1'b1;
          w_load_val   = CLR_V;
        end else if (!inc_held) begin
          w_next_state = S_IDLE;
        end else if (w_expire) begin
          w_next_state = S_INC_RPT;
          w_load       = 1'b1;
          w_load_val   = PER_V;
          w_up_req     = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      S_DEC_WAIT, S_DEC_RPT: begin
        if (inc_held) begin
          w_next_state = S_BOTH;
          w_load       = 1'b1;
          w_load_val   = CLR_V;
        end else if (!dec_held) begin
          w_next_state = S_IDLE;
        end else if (w_expire) begin
          w_next_state = S_DEC_RPT;
          w_load       = 1'b1;
          w_load_val   = PER_V;
          w_dn_req     = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      S_BOTH: begin
        if (w_tmr_zero) begin
          // Clear already done: wait for a full release.
          if (!inc_held && !dec_held) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_BOTH;
          end
        end else if (!(inc_held && dec_held)) begin
          w_next_state = S_IDLE;
        end else if (w_expire) begin
          w_clr_req = 1'b1;
        end else begin
          w_next_state = S_BOTH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (w_up_req && w_can_inc) begin
      w_cnt_next  = r_cnt + WIDTH'(1);
      w_step_next = 1'b1;
    end else if (w_dn_req && w_can_dec) begin
      w_cnt_next  = r_cnt - WIDTH'(1);
      w_step_next = 1'b1;
    end else if (w_clr_req) begin
      w_cnt_next  = CNT_MIN;
      w_step_next = (r_cnt != CNT_MIN);
      w_clr_next  = 1'b1;
    end else begin
      w_cnt_next  = r_cnt;
    end
  end

  // State and registered outputs; led is loaded from the same next value as cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_MIN;
      r_led   <= CNT_MAX;
      r_step  <= 1'b0;
      r_rpt   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_led   <= ~w_cnt_next;
      r_step  <= w_step_next;
      r_rpt   <= (w_next_state == S_INC_RPT) || (w_next_state == S_DEC_RPT);
      r_clr   <= w_clr_next;
    end
  end

  assign cnt        = r_cnt;
  assign led        = r_led;
  assign step       = r_step;
  assign rpt_active = r_rpt;
  assign cleared    = r_clr;

endmodule

// File: tb/tb_updown_ctrl.sv
// Bench for updown_ctrl: one wrapping and one saturating instance share stimulus.
module tb_updown_ctrl;

  localparam int DLY  = 2000;
  localparam int PER  = 1000;
  localparam int CLR  = 3000;
  localparam int MAXV = 63;

  logic clk = 1'b0;
  logic rst, ip, ih, dp, dh;
  logic [5:0] cnt_w, led_w, cnt_s, led_s;
  logic step_w, rpt_w, clr_w, step_s, rpt_s, clr_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = wrapping DUT, 1 = saturating DUT.
  localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_BOTH = 3;
  int m_cnt [2];
  int m_mode[2];
  int m_age [2];
  bit m_done[2];
  bit e_step[2];
  bit e_rpt [2];
  bit e_clr [2];

  updown_ctrl #(.CLK_HZ(1_000_000), .WIDTH(6), .REPEAT_DELAY_MS(2), .REPEAT_PERIOD_MS(1),
                .CLEAR_MS(3), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .inc_press(ip), .inc_held(ih), .dec_press(dp), .dec_held(dh),
    .cnt(cnt_w), .led(led_w), .step(step_w), .rpt_active(rpt_w), .cleared(clr_w));

  updown_ctrl #(.CLK_HZ(1_000_000), .WIDTH(6), .REPEAT_DELAY_MS(2), .REPEAT_PERIOD_MS(1),
                .CLEAR_MS(3), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .inc_press(ip), .inc_held(ih), .dec_press(dp), .dec_held(dh),
    .cnt(cnt_s), .led(led_s), .step(step_s), .rpt_active(rpt_s), .cleared(clr_s));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_mode[i] = M_IDLE; m_age[i] = 0; m_done[i] = 1'b0;
      e_step[i] = 1'b0; e_rpt[i] = 1'b0; e_clr[i] = 1'b0;
    end
  endtask

  task automatic model_move(input int i, input int dir);
    if (i == 1 && ((dir > 0 && m_cnt[i] == MAXV) || (dir < 0 && m_cnt[i] == 0))) begin
      e_step[i] = 1'b0;
    end else begin
      m_cnt[i]  = (m_cnt[i] + dir + MAXV + 1) % (MAXV + 1);
      e_step[i] = 1'b1;
    end
  endtask

  // Behaviour measured as age since the press / since both-held began.
  task automatic model_step(input int i);
    e_step[i] = 1'b0;
    e_clr[i]  = 1'b0;
    case (m_mode[i])
      M_IDLE: begin
        if ((ip && dp) || (ip && dh) || (dp && ih)) begin
          m_mode[i] = M_BOTH; m_age[i] = 0; m_done[i] = 1'b0;
        end else if (ip) begin
          model_move(i, 1); m_mode[i] = M_UP; m_age[i] = 0;
        end else if (dp) begin
          model_move(i, -1); m_mode[i] = M_DN; m_age[i] = 0;
        end
      end
      M_UP, M_DN: begin
        m_age[i]++;
        if ((m_mode[i] == M_UP) ? dh : ih) begin
          m_mode[i] = M_BOTH; m_age[i] = 0; m_done[i] = 1'b0;
        end else if (!((m_mode[i] == M_UP) ? ih : dh)) begin
          m_mode[i] = M_IDLE;
        end else if (m_age[i] >= DLY && ((m_age[i] - DLY) % PER) == 0) begin
          model_move(i, (m_mode[i] == M_UP) ? 1 : -1);
        end
      end
      default: begin
        m_age[i]++;
        if (m_done[i]) begin
          if (!ih && !dh) m_mode[i] = M_IDLE;
        end else if (!(ih && dh)) begin
          m_mode[i] = M_IDLE;
        end else if (m_age[i] == CLR) begin
          e_step[i] = (m_cnt[i] != 0);
          m_cnt[i]  = 0;
          e_clr[i]  = 1'b1;
          m_done[i] = 1'b1;
        end
      end
    endcase
    e_rpt[i] = (m_mode[i] == M_UP || m_mode[i] == M_DN) && m_age[i] >= DLY;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ip = 1'b0; ih = 1'b0; dp = 1'b0; dh = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; ip = 1'b0; ih = 1'b0; dp = 1'b0; dh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_w !== 6'd0 || led_w !== 6'b111111 || step_w !== 1'b0 || rpt_w !== 1'b0 || clr_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: cnt=%0d led=%b step=%b rpt=%b clr=%b, required 0 111111 0 0 0",
               cnt_w, led_w, step_w, rpt_w, clr_w);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_short_press();
    int steps = 0;
    do_reset();
    ip = 1'b1; ih = 1'b1;
    tick();
    ip = 1'b0;
    n_checks++;
    if (cnt_w !== 6'd1 || led_w !== 6'b111110 || step_w !== 1'b1) begin
      n_fail++;
      $display("FAIL short_first: cnt=%0d led=%b step=%b, required 1 111110 1", cnt_w, led_w, step_w);
    end
    for (int k = 2; k <= 12; k++) begin
      if (k == 9) ih = 1'b0;
      tick();
      if (step_w) steps++;
    end
    n_checks++;
    if (steps != 0 || cnt_w !== 6'd1) begin
      n_fail++;
      $display("FAIL short_after: extra steps=%0d cnt=%0d, required 0 and 1", steps, cnt_w);
    end
  endtask

  task automatic test_hold_up();
    int steps[$];
    int exp_steps[4] = '{1, 2001, 3001, 4001};
    int rpt_bad = 0;
    bit ok;
    do_reset();
    ip = 1'b1; ih = 1'b1;
    for (int k = 1; k <= 4500; k++) begin
      tick();
      ip = 1'b0;
      if (step_w) steps.push_back(k);
      if (rpt_w !== (k >= 2001)) rpt_bad++;
    end
    ok = (steps.size() == 4);
    for (int j = 0; j < 4; j++) if (ok && steps[j] != exp_steps[j]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_step_times: %0d steps (first at %0d), required 4 at 1,2001,3001,4001",
               steps.size(), (steps.size() > 0) ? steps[0] : -1);
    end
    n_checks++;
    if (rpt_bad != 0) begin
      n_fail++;
      $display("FAIL hold_rpt_active: %0d wrong cycles, required 0 (high from 2001)", rpt_bad);
    end
    ih = 1'b0;
    tick();
    n_checks++;
    if (cnt_w !== 6'd4 || rpt_w !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: cnt=%0d rpt=%b, required 4 0", cnt_w, rpt_w);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    dp = 1'b1; dh = 1'b1;
    tick();
    dp = 1'b0;
    n_checks++;
    if (cnt_w !== 6'd63 || led_w !== 6'd0 || step_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down: cnt=%0d led=%b step=%b, required 63 000000 1", cnt_w, led_w, step_w);
    end
    n_checks++;
    if (cnt_s !== 6'd0 || led_s !== 6'b111111 || step_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_down: cnt=%0d led=%b step=%b, required 0 111111 0", cnt_s, led_s, step_s);
    end
    dh = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int first_change = -1;
    int n_clr = 0;
    int n_step = 0;
    do_reset();
    for (int p = 0; p < 7; p++) begin
      ip = 1'b1; ih = 1'b1; tick();
      ip = 1'b0; tick();
      ih = 1'b0; tick();
    end
    n_checks++;
    if (cnt_w !== 6'd7) begin
      n_fail++;
      $display("FAIL simul_setup: cnt=%0d, required 7", cnt_w);
    end
    ip = 1'b1; ih = 1'b1; dp = 1'b1; dh = 1'b1;
    for (int k = 1; k <= 3100; k++) begin
      tick();
      ip = 1'b0; dp = 1'b0;
      if (first_change < 0 && cnt_w !== 6'd7) first_change = k;
      if (clr_w) n_clr++;
      if (step_w) n_step++;
    end
    n_checks++;
    if (first_change != 3001 || cnt_w !== 6'd0 || n_clr != 1 || n_step != 1) begin
      n_fail++;
      $display("FAIL simul_clear: change at %0d cnt=%0d clears=%0d steps=%0d, required 3001 0 1 1",
               first_change, cnt_w, n_clr, n_step);
    end
    // Down released, up still held: still in the clear state, presses ignored.
    dh = 1'b0;
    n_step = 0;
    for (int k = 0; k < 20; k++) begin
      ip = (k == 10);
      tick();
      if (step_w || clr_w) n_step++;
    end
    ip = 1'b0; ih = 1'b0;
    tick(); tick();
    n_checks++;
    if (n_step != 0 || cnt_w !== 6'd0) begin
      n_fail++;
      $display("FAIL simul_hold_off: actions=%0d cnt=%0d, required 0 0", n_step, cnt_w);
    end
    ip = 1'b1; ih = 1'b1;
    tick();
    ip = 1'b0; ih = 1'b0;
    n_checks++;
    if (cnt_w !== 6'd1 || step_w !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_back_idle: cnt=%0d step=%b, required 1 1", cnt_w, step_w);
    end
    tick();
  endtask

  task automatic test_opposite_wait();
    int n_step = 0;
    int n_clr = 0;
    int n_rpt = 0;
    do_reset();
    ip = 1'b1; ih = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      tick();
      ip = 1'b0; dp = 1'b0;
      if (k == 500)  begin dh = 1'b1; dp = 1'b1; end
      if (k == 1000) begin ih = 1'b0; dh = 1'b0; end
      if (step_w) n_step++;
      if (clr_w) n_clr++;
      if (rpt_w) n_rpt++;
    end
    n_checks++;
    if (cnt_w !== 6'd1 || n_step != 1 || n_clr != 0 || n_rpt != 0) begin
      n_fail++;
      $display("FAIL opposite_wait: cnt=%0d steps=%0d clears=%0d rpt=%0d, required 1 1 0 0",
               cnt_w, n_step, n_clr, n_rpt);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int n_step = 0;
    do_reset();
    ip = 1'b1; ih = 1'b1;
    for (int k = 1; k <= 5200; k++) begin
      tick();
      ip = 1'b0;
    end
    n_checks++;
    if (cnt_w !== 6'd5 || rpt_w !== 1'b1) begin
      n_fail++;
      $display("FAIL midrpt_setup: cnt=%0d rpt=%b, required 5 1", cnt_w, rpt_w);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (cnt_w !== 6'd0 || led_w !== 6'b111111 || rpt_w !== 1'b0 || step_w !== 1'b0) begin
      n_fail++;
      $display("FAIL midrpt_async: cnt=%0d led=%b rpt=%b step=%b, required 0 111111 0 0",
               cnt_w, led_w, rpt_w, step_w);
    end
    tick();
    rst = 1'b0;
    model_reset();
    // Still held but no new press: an idle controller must not move.
    for (int k = 0; k < 1500; k++) begin
      tick();
      if (step_w || rpt_w) n_step++;
    end
    ih = 1'b0;
    n_checks++;
    if (n_step != 0 || cnt_w !== 6'd0) begin
      n_fail++;
      $display("FAIL midrpt_idle: activity=%0d cnt=%0d, required 0 0", n_step, cnt_w);
    end
    tick();
  endtask

  task automatic test_random();
    int a_len, b_len, b_ofs, tot, prints;
    bit swap;
    logic [5:0] d_cnt[2], d_led[2];
    logic d_step[2], d_rpt[2], d_clr[2];
    prints = 0;
    do_reset();
    for (int e = 0; e < 12; e++) begin
      a_len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(900, 3400));
      case ($urandom_range(0, 3))
        0:       begin b_len = 0; b_ofs = 0; end
        1:       begin b_ofs = 0; b_len = int'($urandom_range(1, 3400)); end
        default: begin b_ofs = int'($urandom_range(1, 400)); b_len = int'($urandom_range(1, 3400)); end
      endcase
      swap = $urandom_range(0, 1);
      tot = ((a_len > b_ofs + b_len) ? a_len : b_ofs + b_len) + 4;
      for (int k = 0; k < tot; k++) begin
        ih = swap ? (k >= b_ofs && k < b_ofs + b_len) : (k < a_len);
        ip = swap ? (k == b_ofs && b_len > 0) : (k == 0);
        dh = swap ? (k < a_len) : (k >= b_ofs && k < b_ofs + b_len);
        dp = swap ? (k == 0) : (k == b_ofs && b_len > 0);
        tick();
        d_cnt[0] = cnt_w; d_led[0] = led_w; d_step[0] = step_w; d_rpt[0] = rpt_w; d_clr[0] = clr_w;
        d_cnt[1] = cnt_s; d_led[1] = led_s; d_step[1] = step_s; d_rpt[1] = rpt_s; d_clr[1] = clr_s;
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (d_cnt[i] !== 6'(m_cnt[i]) || d_led[i] !== ~6'(m_cnt[i]) || d_step[i] !== e_step[i] ||
              d_rpt[i] !== e_rpt[i] || d_clr[i] !== e_clr[i]) begin
            n_fail++;
            if (prints < 20) begin
              prints++;
              $display("FAIL random dut%0d ep%0d cyc%0d: cnt=%0d led=%b step=%b rpt=%b clr=%b, required %0d %b %b %b %b",
                       i, e, k, d_cnt[i], d_led[i], d_step[i], d_rpt[i], d_clr[i],
                       m_cnt[i], ~6'(m_cnt[i]), e_step[i], e_rpt[i], e_clr[i]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_hold_up();
    test_wrap();
    test_simultaneous();
    test_opposite_wait();
    test_reset_mid_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
